// File: rtl/mem_mon_pkg.sv
// Shared types and defaults for the memory bus monitor.
// Holds the trace entry layout, default geometry and the counter saturation helper.
package mem_mon_pkg;

  // One captured write: bus byte address plus the data the core drove.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } trace_entry_t;

  localparam int          DEF_FIFO_DEPTH = 8;
  localparam logic [31:0] DEF_WIN_BASE   = 32'd1000;
  localparam int          DEF_WIN_WORDS  = 20;
  localparam logic [31:0] COUNT_SAT      = 32'hFFFF_FFFF;

  // Increment that sticks at the all-ones value instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == COUNT_SAT) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO for captured bus writes.
// Head entry is presented combinationally; level, pointers and flags are registered.
module trace_fifo
  import mem_mon_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          i_push,
  input  trace_entry_t  i_entry,
  input  logic          i_pop,
  output trace_entry_t  o_head,
  output logic          o_valid,
  output logic [LW-1:0] o_level,
  output logic          o_drop
);

  trace_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A pop on an empty FIFO is ignored, so an empty push+pop is a plain push.
  assign w_do_pop  = i_pop && !w_empty;
  // When full, a push only fits if the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_drop    = i_push && w_full && !i_pop && !clr;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the level register alone decides which slots hold live data.
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/mem_bus_monitor.sv
// Passive snoop of the core-to-memory bus: read/write counters, write trace FIFO,
// protocol error flag and, when MEM_MON_MIN_TRACK_EN is defined, a signed-minimum
// tracker over the array window. Without the macro the min outputs are tied to zero.
module mem_bus_monitor
  import mem_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef MEM_MON_MIN_TRACK_EN
  , parameter logic [31:0] WIN_BASE  = DEF_WIN_BASE
  , parameter int          WIN_WORDS = DEF_WIN_WORDS
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   inst_data_adr,
  input  logic [31:0]                   mem_data_in,
  input  logic                          trc_pop,
  output logic                          trc_valid,
  output logic [31:0]                   trc_adr,
  output logic [31:0]                   trc_data,
  output logic [$clog2(FIFO_DEPTH):0]   trc_level,
  output logic                          trc_overflow,
  output logic                          proto_err,
  output logic [31:0]                   rd_count,
  output logic [31:0]                   wr_count,
  output logic                          min_valid,
  output logic [31:0]                   min_value,
  output logic [31:0]                   min_index
);

  trace_entry_t w_entry;
  trace_entry_t w_head;
  logic         w_drop;

  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic        r_overflow;
  logic        r_proto_err;

  assign w_entry = '{adr: inst_data_adr, data: mem_data_in};

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .i_push  (mem_write),
    .i_entry (w_entry),
    .i_pop   (trc_pop),
    .o_head  (w_head),
    .o_valid (trc_valid),
    .o_level (trc_level),
    .o_drop  (w_drop)
  );

  assign trc_adr  = w_head.adr;
  assign trc_data = w_head.data;

  // Transaction counters and sticky error flags; clear wins over that cycle's events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (clr) begin
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (mem_read)              r_rd_count  <= sat_inc(r_rd_count);
      if (mem_write)             r_wr_count  <= sat_inc(r_wr_count);
      if (w_drop)                r_overflow  <= 1'b1;
      if (mem_read && mem_write) r_proto_err <= 1'b1;
    end
  end

  assign rd_count     = r_rd_count;
  assign wr_count     = r_wr_count;
  assign trc_overflow = r_overflow;
  assign proto_err    = r_proto_err;

`ifdef MEM_MON_MIN_TRACK_EN
  localparam logic [31:0] WIN_SPAN = 32'(4 * WIN_WORDS);

  logic [31:0] w_win_off;
  logic        w_in_win;
  logic        w_take;
  logic        r_min_valid;
  logic [31:0] r_min_value;
  logic [31:0] r_min_index;

  assign w_win_off = inst_data_adr - WIN_BASE;
  assign w_in_win  = (inst_data_adr >= WIN_BASE) && (w_win_off < WIN_SPAN) &&
                     (inst_data_adr[1:0] == 2'b00);
  // Strict less-than keeps the earliest index on ties.
  assign w_take    = mem_write && w_in_win &&
                     (!r_min_valid || ($signed(mem_data_in) < $signed(r_min_value)));

  // Running signed minimum over aligned in-window writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min_valid <= 1'b0;
      r_min_value <= '0;
      r_min_index <= '0;
    end else if (clr) begin
      r_min_valid <= 1'b0;
      r_min_value <= '0;
      r_min_index <= '0;
    end else if (w_take) begin
      r_min_valid <= 1'b1;
      r_min_value <= mem_data_in;
      r_min_index <= {2'b00, w_win_off[31:2]};
    end
  end

  assign min_valid = r_min_valid;
  assign min_value = r_min_value;
  assign min_index = r_min_index;
`else
  assign min_valid = 1'b0;
  assign min_value = '0;
  assign min_index = '0;
`endif

endmodule

// File: tb/tb_mem_bus_monitor.sv
// Self-checking bench for mem_bus_monitor: a table of single-cycle vectors with
// hand-computed expectations, plus sequences for overflow, full push+pop and async reset.
// Min expectations apply when MEM_MON_MIN_TRACK_EN is defined, otherwise zero is expected.
module tb_mem_bus_monitor;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [31:0]   inst_data_adr = '0;
  logic [31:0]   mem_data_in = '0;
  logic          trc_pop = 1'b0;
  logic          trc_valid;
  logic [31:0]   trc_adr;
  logic [31:0]   trc_data;
  logic [LW-1:0] trc_level;
  logic          trc_overflow;
  logic          proto_err;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
  logic          min_valid;
  logic [31:0]   min_value;
  logic [31:0]   min_index;

  int n_total = 0;
  int n_pass  = 0;

  mem_bus_monitor #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .inst_data_adr (inst_data_adr),
    .mem_data_in   (mem_data_in),
    .trc_pop       (trc_pop),
    .trc_valid     (trc_valid),
    .trc_adr       (trc_adr),
    .trc_data      (trc_data),
    .trc_level     (trc_level),
    .trc_overflow  (trc_overflow),
    .proto_err     (proto_err),
    .rd_count      (rd_count),
    .wr_count      (wr_count),
    .min_valid     (min_valid),
    .min_value     (min_value),
    .min_index     (min_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, pop, cl;
    logic [31:0] adr, data;
    int          lvl;
    logic [31:0] hadr, hdata;
    logic [31:0] rdc, wrc;
    logic        ovf, perr, mv;
    logic [31:0] mval, midx;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic rd, input logic wr, input logic pop, input logic cl,
                     input logic [31:0] adr, input logic [31:0] data, input int lvl,
                     input logic [31:0] hadr, input logic [31:0] hdata,
                     input logic [31:0] rdc, input logic [31:0] wrc,
                     input logic ovf, input logic perr, input logic mv,
                     input logic [31:0] mval, input logic [31:0] midx);
    vec_t v;
    v.rd = rd; v.wr = wr; v.pop = pop; v.cl = cl; v.adr = adr; v.data = data;
    v.lvl = lvl; v.hadr = hadr; v.hdata = hdata; v.rdc = rdc; v.wrc = wrc;
    v.ovf = ovf; v.perr = perr; v.mv = mv; v.mval = mval; v.midx = midx;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] adr,
                     input logic [31:0] data, input logic pop, input logic cl);
    mem_read = rd; mem_write = wr; inst_data_adr = adr; mem_data_in = data;
    trc_pop = pop; clr = cl;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; trc_pop = 1'b0; clr = 1'b0;
  endtask

  task automatic check_min(input string tag, input logic mv, input logic [31:0] mval,
                           input logic [31:0] midx);
`ifdef MEM_MON_MIN_TRACK_EN
    check({tag, ".min_valid"}, {31'd0, min_valid}, {31'd0, mv});
    check({tag, ".min_value"}, min_value, mval);
    check({tag, ".min_index"}, min_index, midx);
`else
    check({tag, ".min_valid"}, {31'd0, min_valid}, 32'd0);
    check({tag, ".min_value"}, min_value, 32'd0);
    check({tag, ".min_index"}, min_index, 32'd0);
    if (mv && mval == 32'hDEAD_BEEF && midx == 32'hDEAD_BEEF) $display("unreachable");
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".level"},    32'(trc_level), 32'd0);
    check({tag, ".valid"},    {31'd0, trc_valid}, 32'd0);
    check({tag, ".rd_count"}, rd_count, 32'd0);
    check({tag, ".wr_count"}, wr_count, 32'd0);
    check({tag, ".overflow"}, {31'd0, trc_overflow}, 32'd0);
    check({tag, ".proto_err"},{31'd0, proto_err}, 32'd0);
    check_min(tag, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //   rd wr pop clr  adr      data          lvl head_adr head_data    rd wr ovf perr mv min_value     idx
    add(0, 1, 0, 0, 32'd1000, 32'd5,        1, 32'd1000, 32'd5,        0, 1,  0, 0, 1, 32'd5,        0);
    add(0, 1, 0, 0, 32'd1004, -32'sd2,      2, 32'd1000, 32'd5,        0, 2,  0, 0, 1, -32'sd2,      1);
    add(0, 1, 0, 0, 32'd1008, 32'd7,        3, 32'd1000, 32'd5,        0, 3,  0, 0, 1, -32'sd2,      1);
    add(0, 1, 0, 0, 32'd1012, -32'sd4,      4, 32'd1000, 32'd5,        0, 4,  0, 0, 1, -32'sd4,      3);
    add(0, 1, 0, 0, 32'd1016, -32'sd4,      5, 32'd1000, 32'd5,        0, 5,  0, 0, 1, -32'sd4,      3);
    add(0, 1, 0, 0, 32'd1002, -32'sd9,      6, 32'd1000, 32'd5,        0, 6,  0, 0, 1, -32'sd4,      3);
    add(0, 1, 0, 0, 32'd1080, -32'sd100,    7, 32'd1000, 32'd5,        0, 7,  0, 0, 1, -32'sd4,      3);
    add(0, 1, 0, 0, 32'd1076, -32'sd5,      8, 32'd1000, 32'd5,        0, 8,  0, 0, 1, -32'sd5,      19);
    add(0, 1, 0, 0, 32'd900,  -32'sd50,     8, 32'd1000, 32'd5,        0, 9,  1, 0, 1, -32'sd5,      19);
    add(0, 1, 1, 0, 32'd1020, -32'sd6,      8, 32'd1004, -32'sd2,      0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        7, 32'd1008, 32'd7,        0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        6, 32'd1012, -32'sd4,      0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        5, 32'd1016, -32'sd4,      0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        4, 32'd1002, -32'sd9,      0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        3, 32'd1080, -32'sd100,    0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        2, 32'd1076, -32'sd5,      0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        1, 32'd1020, -32'sd6,      0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        0, 32'd0,    32'd0,        0, 10, 1, 0, 1, -32'sd6,      5);
    add(0, 0, 1, 0, 32'd0,    32'd0,        0, 32'd0,    32'd0,        0, 10, 1, 0, 1, -32'sd6,      5);
    add(1, 1, 1, 0, 32'd1024, 32'd3,        1, 32'd1024, 32'd3,        1, 11, 1, 1, 1, -32'sd6,      5);
    add(1, 1, 0, 1, 32'd1000, -32'sd1,      0, 32'd0,    32'd0,        0, 0,  0, 0, 0, 32'd0,        0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cyc(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].data, vecs[i].pop, vecs[i].cl);
      check({tag, ".level"},     32'(trc_level), 32'(vecs[i].lvl));
      check({tag, ".valid"},     {31'd0, trc_valid}, {31'd0, vecs[i].lvl != 0});
      if (vecs[i].lvl != 0) begin
        check({tag, ".head_adr"},  trc_adr,  vecs[i].hadr);
        check({tag, ".head_data"}, trc_data, vecs[i].hdata);
      end
      check({tag, ".rd_count"},  rd_count, vecs[i].rdc);
      check({tag, ".wr_count"},  wr_count, vecs[i].wrc);
      check({tag, ".overflow"},  {31'd0, trc_overflow}, {31'd0, vecs[i].ovf});
      check({tag, ".proto_err"}, {31'd0, proto_err}, {31'd0, vecs[i].perr});
      check_min(tag, vecs[i].mv, vecs[i].mval, vecs[i].midx);
    end

    // Nine writes into an empty FIFO: ninth is dropped, drain returns the first eight in order.
    for (int i = 0; i < 9; i++) cyc(0, 1, 32'(2000 + 4 * i), 32'(100 + i), 0, 0);
    check("ovf9.level",    32'(trc_level), 32'd8);
    check("ovf9.overflow", {31'd0, trc_overflow}, 32'd1);
    check("ovf9.wr_count", wr_count, 32'd9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.adr", i),  trc_adr,  32'(2000 + 4 * i));
      check($sformatf("drain%0d.data", i), trc_data, 32'(100 + i));
      cyc(0, 0, 32'd0, 32'd0, 1, 0);
    end
    check("drain.valid", {31'd0, trc_valid}, 32'd0);
    check("drain.level", 32'(trc_level), 32'd0);

    // Full FIFO with simultaneous push and pop: level holds, no overflow, head advances.
    cyc(0, 0, 32'd0, 32'd0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 32'(3000 + 4 * i), 32'(i), 0, 0);
    cyc(0, 1, 32'd3100, 32'd77, 1, 0);
    check("fullpp.level",    32'(trc_level), 32'd8);
    check("fullpp.overflow", {31'd0, trc_overflow}, 32'd0);
    check("fullpp.head_adr", trc_adr,  32'd3004);
    check("fullpp.head_dat", trc_data, 32'd1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 32'd0, 32'd0, 1, 0);
    check("fullpp.tail_adr", trc_adr,  32'd3100);
    check("fullpp.tail_dat", trc_data, 32'd77);
    check("fullpp.tail_lvl", 32'(trc_level), 32'd1);

    // Asynchronous reset between edges clears everything before the next edge.
    cyc(1, 0, 32'd0, 32'd0, 0, 0);
    cyc(0, 1, 32'd1000, -32'sd3, 0, 0);
    cyc(0, 1, 32'd1004, 32'd8, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 32'd1008, 32'd42, 0, 0);
    check("post_rst.level",    32'(trc_level), 32'd1);
    check("post_rst.head_adr", trc_adr,  32'd1008);
    check("post_rst.head_dat", trc_data, 32'd42);
    check("post_rst.wr_count", wr_count, 32'd1);
    check_min("post_rst", 1'b1, 32'd42, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
